ball_engine: RTL and testbench
==============================

// Module: ball_engine
// PURPOSE
//  Ball state machine for the pong playfield. Holds the ball centre (x,y) and
//  direction, steps it once per game tick, and reflects it off the side walls
//  and both paddles. Detects misses and runs the miss/serve sequence.
//  Sits upstream of the pong renderer and the CPU paddle tracker (ball_x,
//  ball_y, in_play), and of the score/sound logic (miss/hit pulses).
// PARAMETERS
//  X_MIN       50   left wall x (inclusive); ball edge never goes below it
//  X_MAX       749  right wall x (inclusive)
//  Y_MIN       30   top miss line; ball top edge at or above it = cpu miss
//  Y_MAX       570  bottom miss line; ball bottom edge at or below it = player miss
//  CPU_PAD_Y   60   cpu paddle bottom edge y
//  PLY_PAD_Y   540  player paddle top edge y
//  PAD_HW      12   paddle half width
//  BALL_R      4    ball half size (ball is a (2R+1) square)
//  STEP        1    pixels moved per tick on each axis
//  X_CTR/Y_CTR 399/300  serve position
//  SERVE_TICKS 250  ticks ball is held at centre before moving
//  MISS_TICKS  125  ticks ball is frozen after a miss
// PORTS
//  clk          in   1   system clock (50 MHz)
//  rst          in   1   asynchronous, active-low reset
//  tick         in   1   one-clk-wide game step strobe (~500 Hz)
//  paddle_pos   in   10  player paddle centre x
//  cpu_pos      in   10  cpu paddle centre x
//  ball_x       out  11  ball centre x
//  ball_y       out  10  ball centre y
//  dir_right    out  1   1 = ball moving +x
//  dir_down     out  1   1 = ball moving +y (toward player)
//  in_play      out  1   1 only in state MOVE
//  hit          out  1   1-clk pulse: paddle reflection
//  player_miss  out  1   1-clk pulse: ball passed player paddle (cpu scores)
//  cpu_miss     out  1   1-clk pulse: ball passed cpu paddle (player scores)
// BEHAVIOUR
//  Reset (rst=0, async): state=SERVE, cnt=0, ball_x=X_CTR, ball_y=Y_CTR,
//   dir_right=1, dir_down=1, in_play=0, hit/player_miss/cpu_miss=0.
//  All state, position and counters change only on clk edges with tick=1.
//  Pulses are registered: asserted the clk after the deciding tick, 1 clk wide.
//  States: SERVE -> MOVE -> MISS -> SERVE.
//  SERVE: ball at centre; cnt++ each tick; at cnt==SERVE_TICKS-1 -> MOVE, cnt=0.
//  MOVE (per tick), nx=x+-STEP, ny=y+-STEP, compared in 12-bit signed (no wrap):
//   X: nx-BALL_R<=X_MIN -> x=X_MIN+BALL_R, dir_right=1;
//      nx+BALL_R>=X_MAX -> x=X_MAX-BALL_R, dir_right=0; else x=nx.
//   Y down: crossing (y+R<PLY_PAD_Y, ny+R>=PLY_PAD_Y) and |x-paddle_pos|
//      <=PAD_HW+BALL_R -> y=PLY_PAD_Y-BALL_R, dir_down=0, hit.
//      Else ny+R>=Y_MAX -> y=Y_MAX-R, player_miss, ->MISS. Else y=ny.
//   Y up: crossing (y-R>CPU_PAD_Y, ny-R<=CPU_PAD_Y) and |x-cpu_pos|
//      <=PAD_HW+BALL_R -> y=CPU_PAD_Y+BALL_R, dir_down=1, hit.
//      Else ny-R<=Y_MIN -> y=Y_MIN+R, cpu_miss, ->MISS. Else y=ny.
//   Overlap test uses x before the step. Paddle hit beats miss.
//   X and Y resolved in the same tick (corner = both axes reflect).
//  MISS: position frozen; cnt++; at cnt==MISS_TICKS-1 -> SERVE, cnt=0;
//   ball reloaded to centre; dir_down set toward side that conceded
//   (player_miss -> dir_down=1, cpu_miss -> dir_down=0); dir_right kept.
//  Paddle inputs sampled only in MOVE; never change position or state directly.
//  Reset mid-MOVE/MISS: immediate return to reset values, no pulse emitted.
// TESTING
//  1 rst low then high, ticks: in_play=0 for 250 ticks; MOVE on tick 250; x,y=399,300 until then.
//  2 MOVE, dir_right=0, x=55: next tick x=54 (X_MIN+R), dir_right=1; next tick x=55.
//  3 dir_down=1, y=535, paddle_pos=x+16: tick -> y=536, dir_down=0, hit 1 clk.
//  4 Same with paddle_pos=x+17: no hit; ball continues to y=566, player_miss 1 clk; 125 ticks later SERVE at centre with dir_down=1.
//  5 Corner: x=745 right, y=535 down, paddle under: one tick flips both dirs.
//  6 tick held 0 for 1000 clks: outputs static; rst pulse mid-MISS -> reset values, no pulses.

Source files
------------

// File: rtl/ball_engine.sv
// ball_engine: pong ball position/direction state machine with wall and paddle
// reflection, miss detection and the serve/miss hold sequence.
module ball_engine #(
    parameter logic signed [11:0] X_MIN     = 12'sd50,
    parameter logic signed [11:0] X_MAX     = 12'sd749,
    parameter logic signed [11:0] Y_MIN     = 12'sd30,
    parameter logic signed [11:0] Y_MAX     = 12'sd570,
    parameter logic signed [11:0] CPU_PAD_Y = 12'sd60,
    parameter logic signed [11:0] PLY_PAD_Y = 12'sd540,
    parameter logic signed [11:0] PAD_HW    = 12'sd12,
    parameter logic signed [11:0] BALL_R    = 12'sd4,
    parameter logic signed [11:0] STEP      = 12'sd1,
    parameter logic [10:0]        X_CTR     = 11'd399,
    parameter logic [9:0]         Y_CTR     = 10'd300,
    parameter int                 SERVE_TICKS = 250,
    parameter int                 MISS_TICKS  = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [9:0]  paddle_pos,
    input  logic [9:0]  cpu_pos,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic        dir_right,
    output logic        dir_down,
    output logic        in_play,
    output logic        hit,
    output logic        player_miss,
    output logic        cpu_miss
);
    localparam logic [1:0] SERVE = 2'd0;
    localparam logic [1:0] MOVE  = 2'd1;
    localparam logic [1:0] MISS  = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic signed [11:0] sx, sy, nx, ny, dp, dc;
    logic [10:0] nx_s, x_n;
    logic [9:0] ny_s, y_n;
    logic x_lo, x_hi, ply_ov, cpu_ov, ply_hit, cpu_hit, pad_hit, miss, dr_n, dd_n;

    assign in_play = state == MOVE;

    // Limits are compared in signed 12-bit so a step past zero never wraps.
    always_comb begin
        sx      = $signed({1'b0, ball_x});
        sy      = $signed({2'b0, ball_y});
        nx      = dir_right ? sx + STEP : sx - STEP;
        ny      = dir_down ? sy + STEP : sy - STEP;
        nx_s    = dir_right ? ball_x + 11'(STEP) : ball_x - 11'(STEP);
        ny_s    = dir_down ? ball_y + 10'(STEP) : ball_y - 10'(STEP);
        dp      = sx - $signed({2'b0, paddle_pos});
        dc      = sx - $signed({2'b0, cpu_pos});
        ply_ov  = (dp[11] ? -dp : dp) <= PAD_HW + BALL_R;
        cpu_ov  = (dc[11] ? -dc : dc) <= PAD_HW + BALL_R;
        x_lo    = nx - BALL_R <= X_MIN;
        x_hi    = nx + BALL_R >= X_MAX;
        ply_hit = dir_down && sy + BALL_R < PLY_PAD_Y && ny + BALL_R >= PLY_PAD_Y && ply_ov;
        cpu_hit = !dir_down && sy - BALL_R > CPU_PAD_Y && ny - BALL_R <= CPU_PAD_Y && cpu_ov;
        pad_hit = ply_hit || cpu_hit;
        miss    = !pad_hit && (dir_down ? ny + BALL_R >= Y_MAX : ny - BALL_R <= Y_MIN);
        x_n     = x_lo ? 11'(X_MIN + BALL_R) : x_hi ? 11'(X_MAX - BALL_R) : nx_s;
        y_n     = ply_hit ? 10'(PLY_PAD_Y - BALL_R) : cpu_hit ? 10'(CPU_PAD_Y + BALL_R) :
                  miss ? (dir_down ? 10'(Y_MAX - BALL_R) : 10'(Y_MIN + BALL_R)) : ny_s;
        dr_n    = x_lo || (!x_hi && dir_right);
        dd_n    = dir_down ^ pad_hit;
    end

    // dir_down is left untouched through MISS: it already points at the side that conceded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SERVE;
            cnt         <= 8'd0;
            ball_x      <= X_CTR;
            ball_y      <= Y_CTR;
            dir_right   <= 1'b1;
            dir_down    <= 1'b1;
            hit         <= 1'b0;
            player_miss <= 1'b0;
            cpu_miss    <= 1'b0;
        end else begin
            hit         <= 1'b0;
            player_miss <= 1'b0;
            cpu_miss    <= 1'b0;
            if (tick) begin
                if (state == SERVE) begin
                    state <= cnt == 8'(SERVE_TICKS - 1) ? MOVE : SERVE;
                    cnt   <= cnt == 8'(SERVE_TICKS - 1) ? 8'd0 : cnt + 8'd1;
                end else if (state == MOVE) begin
                    ball_x      <= x_n;
                    ball_y      <= y_n;
                    dir_right   <= dr_n;
                    dir_down    <= dd_n;
                    hit         <= pad_hit;
                    player_miss <= miss && dir_down;
                    cpu_miss    <= miss && !dir_down;
                    state       <= miss ? MISS : MOVE;
                end else if (state == MISS) begin
                    if (cnt == 8'(MISS_TICKS - 1)) begin
                        state  <= SERVE;
                        cnt    <= 8'd0;
                        ball_x <= X_CTR;
                        ball_y <= Y_CTR;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else begin
                    state <= SERVE;
                    cnt   <= 8'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed walk of the ball through serve, walls, both paddles,
// both misses, a wall+paddle corner, idle ticks and a mid-miss reset.
module tb_ball_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [9:0]  paddle_pos, cpu_pos, paddle_man, cpu_man;
    logic        track_ply, track_cpu;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic        dir_right, dir_down, in_play, hit, player_miss, cpu_miss;
    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pc_save;

    always #5 clk = ~clk;

    // Tracking paddles follow the ball so every crossing is returned.
    assign paddle_pos = track_ply ? ball_x[9:0] : paddle_man;
    assign cpu_pos    = track_cpu ? ball_x[9:0] : cpu_man;

    always @(negedge clk) if (hit || player_miss || cpu_miss) pulse_cnt <= pulse_cnt + 1;

    ball_engine dut (
        .clk(clk), .rst(rst), .tick(tick), .paddle_pos(paddle_pos), .cpu_pos(cpu_pos),
        .ball_x(ball_x), .ball_y(ball_y), .dir_right(dir_right), .dir_down(dir_down),
        .in_play(in_play), .hit(hit), .player_miss(player_miss), .cpu_miss(cpu_miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y, input logic dr, input logic dd);
        chk({tag, " x"}, 32'(ball_x), 32'(x));
        chk({tag, " y"}, 32'(ball_y), 32'(y));
        chk({tag, " dir_right"}, 32'(dir_right), 32'(dr));
        chk({tag, " dir_down"}, 32'(dir_down), 32'(dd));
    endtask

    task automatic chk_reset(input string tag);
        chk_ball(tag, 399, 300, 1'b1, 1'b1);
        chk({tag, " in_play"}, 32'(in_play), 32'd0);
        chk({tag, " pulses"}, {29'd0, hit, player_miss, cpu_miss}, 32'd0);
    endtask

    // n consecutive ticks (tick held high n clocks), ends on a negedge with tick low
    task automatic run(input int n);
        @(negedge clk);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; track_ply = 1'b0; track_cpu = 1'b0;
        paddle_man = 10'd650; cpu_man = 10'd384;
        #12;
        chk_reset("reset");
        @(negedge clk) rst = 1'b1;
        // serve hold
        run(249);
        chk("serve in_play", 32'(in_play), 32'd0);
        chk_ball("serve hold", 399, 300, 1'b1, 1'b1);
        run(1);
        chk("serve->move", 32'(in_play), 32'd1);
        chk_ball("move start", 399, 300, 1'b1, 1'b1);
        // player paddle at x+16 returns the ball
        run(235);
        chk_ball("pre player", 634, 535, 1'b1, 1'b1);
        chk("pre player hit", 32'(hit), 32'd0);
        run(1);
        chk_ball("player hit", 635, 536, 1'b1, 1'b0);
        chk("player hit pulse", 32'(hit), 32'd1);
        @(negedge clk);
        chk("hit 1clk", 32'(hit), 32'd0);
        // right wall, then cpu paddle
        run(110);
        chk_ball("right wall", 745, 426, 1'b0, 1'b0);
        run(362);
        chk_ball("cpu hit", 383, 64, 1'b0, 1'b1);
        chk("cpu hit pulse", 32'(hit), 32'd1);
        // left wall clamp
        run(328);
        chk_ball("pre left", 55, 392, 1'b0, 1'b1);
        run(1);
        chk_ball("left wall", 54, 393, 1'b1, 1'b1);
        run(1);
        chk_ball("after left", 55, 394, 1'b1, 1'b1);
        // tracked player return, then cpu paddle away -> cpu miss
        track_ply = 1'b1; track_cpu = 1'b1;
        run(142);
        chk_ball("tracked hit", 197, 536, 1'b1, 1'b0);
        chk("tracked hit pulse", 32'(hit), 32'd1);
        track_cpu = 1'b0; cpu_man = 10'd0;
        run(502);
        chk_ball("cpu miss", 699, 34, 1'b1, 1'b0);
        chk("cpu miss pulse", 32'(cpu_miss), 32'd1);
        chk("cpu miss no pmiss", 32'(player_miss), 32'd0);
        chk("cpu miss in_play", 32'(in_play), 32'd0);
        @(negedge clk);
        chk("cpu miss 1clk", 32'(cpu_miss), 32'd0);
        run(124);
        chk_ball("miss frozen", 699, 34, 1'b1, 1'b0);
        run(1);
        chk_ball("serve after cpu miss", 399, 300, 1'b1, 1'b0);
        chk("serve in_play 2", 32'(in_play), 32'd0);
        // long tracked rally up to the right-wall / player-paddle corner
        track_ply = 1'b1; track_cpu = 1'b1;
        run(250);
        chk("move 2", 32'(in_play), 32'd1);
        run(43187);
        chk_ball("pre corner", 744, 535, 1'b1, 1'b1);
        run(1);
        chk_ball("corner", 745, 536, 1'b0, 1'b0);
        chk("corner hit", 32'(hit), 32'd1);
        @(negedge clk);
        chk("corner hit 1clk", 32'(hit), 32'd0);
        // fresh game: paddle at x+17 misses
        @(negedge clk) rst = 1'b0;
        #1 chk_reset("reset 2");
        @(negedge clk) rst = 1'b1;
        track_ply = 1'b0; track_cpu = 1'b0; paddle_man = 10'd651; cpu_man = 10'd0;
        run(250);
        run(235);
        chk_ball("pre miss", 634, 535, 1'b1, 1'b1);
        run(1);
        chk_ball("no hit +17", 635, 536, 1'b1, 1'b1);
        chk("no hit pulse", 32'(hit), 32'd0);
        run(30);
        chk_ball("player miss", 665, 566, 1'b1, 1'b1);
        chk("player miss pulse", 32'(player_miss), 32'd1);
        chk("player miss in_play", 32'(in_play), 32'd0);
        @(negedge clk);
        chk("player miss 1clk", 32'(player_miss), 32'd0);
        run(124);
        chk_ball("pmiss frozen", 665, 566, 1'b1, 1'b1);
        run(1);
        chk_ball("serve after pmiss", 399, 300, 1'b1, 1'b1);
        // miss again, idle without ticks, then reset mid-MISS
        run(250);
        run(266);
        chk("player miss 2", 32'(player_miss), 32'd1);
        run(10);
        pc_save = pulse_cnt;
        repeat (1000) @(negedge clk);
        chk_ball("idle static", 665, 566, 1'b1, 1'b1);
        chk("idle in_play", 32'(in_play), 32'd0);
        chk("idle pulses", 32'(pulse_cnt), 32'(pc_save));
        #2 rst = 1'b0;
        #1 chk_reset("async reset mid-miss");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run(5);
        chk_reset("after reset ticks");
        chk("reset pulses", 32'(pulse_cnt), 32'(pc_save));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
